// File: rtl/timer_sched.sv
// Multi-channel timer scheduler: one shared prescaler tick sweeps NCH down-counters, one channel per clock.
// Optional tick-overrun detection is compiled in with `define TIMER_SCHED_OVERRUN_EN.
module timer_sched #(
   parameter int unsigned NCH = 4,
   parameter int unsigned CHW = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_in,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CHW-1:0]   cmd_ch,
   input  logic [15:0]      cmd_load,
   input  logic             cmd_oneshot,
   output logic [NCH-1:0]   irq_pending,
   output logic             irq,
   output logic             busy
`ifdef TIMER_SCHED_OVERRUN_EN
   ,
   output logic             overrun
`endif
);

   localparam int unsigned CNTW = 16;
   localparam logic [CHW-1:0] LAST_IDX = CHW'(NCH - 1);

   localparam logic [1:0] OP_STOP    = 2'b00;
   localparam logic [1:0] OP_START   = 2'b01;
   localparam logic [1:0] OP_CLR_IRQ = 2'b10;
   localparam logic [1:0] OP_CLR_OVR = 2'b11;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SWEEP = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [CHW-1:0]  idx_q, idx_d;

   logic [NCH-1:0]  run_q;
   logic [NCH-1:0]  oneshot_q;
   logic [NCH-1:0]  pend_q;
   logic [CNTW-1:0] load_q  [NCH];
   logic [CNTW-1:0] count_q [NCH];

   logic            cmd_fire;
   logic            ch_ok;
   logic            sweep_act;

   assign cmd_fire  = cmd_valid && cmd_ready;
   assign ch_ok     = (32'(cmd_ch) < NCH);
   assign sweep_act = (state_q == S_SWEEP) && run_q[idx_q];

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Next state: a tick in IDLE starts a sweep; the sweep walks idx from 0 to NCH-1
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (tick_in) begin
               state_d = S_SWEEP;
               idx_d   = '0;
            end
         end
         S_SWEEP: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + CHW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Registered handshake/status, derived from the next state so they track the FSM exactly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
      end else begin
         cmd_ready <= (state_d == S_IDLE);
         busy      <= (state_d == S_SWEEP);
      end
   end

   // Channel state: commands land only in IDLE, sweep updates only in SWEEP, so they never collide
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q     <= '0;
         oneshot_q <= '0;
         pend_q    <= '0;
         for (int i = 0; i < NCH; i++) begin
            load_q[i]  <= '0;
            count_q[i] <= '0;
         end
      end else begin
         if (cmd_fire && ch_ok) begin
            case (cmd_op)
               OP_STOP: begin
                  run_q[cmd_ch] <= 1'b0;
               end
               OP_START: begin
                  load_q[cmd_ch]    <= cmd_load;
                  count_q[cmd_ch]   <= cmd_load;
                  oneshot_q[cmd_ch] <= cmd_oneshot;
                  run_q[cmd_ch]     <= 1'b1;
               end
               OP_CLR_IRQ: begin
                  pend_q[cmd_ch] <= 1'b0;
               end
               default: begin
               end
            endcase
         end
         if (sweep_act) begin
            if (count_q[idx_q] == '0) begin
               pend_q[idx_q] <= 1'b1;
               if (oneshot_q[idx_q]) begin
                  run_q[idx_q] <= 1'b0;
               end else begin
                  count_q[idx_q] <= load_q[idx_q];
               end
            end else begin
               count_q[idx_q] <= count_q[idx_q] - CNTW'(1);
            end
         end
      end
   end

   assign irq_pending = pend_q;
   assign irq         = |pend_q;

`ifdef TIMER_SCHED_OVERRUN_EN
   logic ovr_set;
   logic ovr_clr;

   assign ovr_set = (state_q == S_SWEEP) && tick_in;
   assign ovr_clr = cmd_fire && (cmd_op == OP_CLR_OVR);

   // Sticky overrun: a late tick outranks a clear on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun <= 1'b0;
      end else if (ovr_set) begin
         overrun <= 1'b1;
      end else if (ovr_clr) begin
         overrun <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_timer_sched.sv
// Self-checking bench for timer_sched: directed scenarios plus randomized commands/ticks vs. a tick-level model.
// Overrun checks are included when TIMER_SCHED_OVERRUN_EN is defined.
module tb_timer_sched;

   localparam int unsigned NCH  = 4;
   localparam int unsigned CHW  = 2;
   localparam int unsigned NCH2 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             tick_in;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CHW-1:0]   cmd_ch;
   logic [15:0]      cmd_load;
   logic             cmd_oneshot;
   logic [NCH-1:0]   irq_pending;
   logic             irq;
   logic             busy;

   logic             cmd2_valid;
   logic             cmd2_ready;
   logic [1:0]       cmd2_op;
   logic [CHW-1:0]   cmd2_ch;
   logic [15:0]      cmd2_load;
   logic             cmd2_oneshot;
   logic [NCH2-1:0]  irq2_pending;
   logic             irq2;
   logic             busy2;
`ifdef TIMER_SCHED_OVERRUN_EN
   logic             overrun;
   logic             overrun2;
`endif

   timer_sched #(.NCH(NCH), .CHW(CHW)) u_dut (
      .clk(clk), .rst_n(rst_n), .tick_in(tick_in),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_ch(cmd_ch),
      .cmd_load(cmd_load), .cmd_oneshot(cmd_oneshot),
      .irq_pending(irq_pending), .irq(irq), .busy(busy)
`ifdef TIMER_SCHED_OVERRUN_EN
      , .overrun(overrun)
`endif
   );

   // Non-power-of-two instance so that cmd_ch == NCH is reachable
   timer_sched #(.NCH(NCH2), .CHW(CHW)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .tick_in(tick_in),
      .cmd_valid(cmd2_valid), .cmd_ready(cmd2_ready), .cmd_op(cmd2_op), .cmd_ch(cmd2_ch),
      .cmd_load(cmd2_load), .cmd_oneshot(cmd2_oneshot),
      .irq_pending(irq2_pending), .irq(irq2), .busy(busy2)
`ifdef TIMER_SCHED_OVERRUN_EN
      , .overrun(overrun2)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: whole tick applied at once
   bit m_run  [NCH];
   bit m_os   [NCH];
   int m_load [NCH];
   int m_cnt  [NCH];
   bit m_pend [NCH];
   bit m_ovr;

   task automatic m_reset();
      for (int i = 0; i < NCH; i++) begin
         m_run[i] = 0; m_os[i] = 0; m_load[i] = 0; m_cnt[i] = 0; m_pend[i] = 0;
      end
      m_ovr = 0;
   endtask

   task automatic m_cmd(input int op, input int ch, input int ld, input bit os);
      if (op == 3) m_ovr = 0;
      else if (ch < NCH) begin
         if (op == 0) m_run[ch] = 0;
         else if (op == 1) begin
            m_load[ch] = ld; m_cnt[ch] = ld; m_os[ch] = os; m_run[ch] = 1;
         end else m_pend[ch] = 0;
      end
   endtask

   task automatic m_tick();
      for (int i = 0; i < NCH; i++) begin
         if (m_run[i]) begin
            if (m_cnt[i] == 0) begin
               m_pend[i] = 1;
               if (m_os[i]) m_run[i] = 0;
               else m_cnt[i] = m_load[i];
            end else m_cnt[i] = m_cnt[i] - 1;
         end
      end
   endtask

   function automatic logic [NCH-1:0] m_vec();
      logic [NCH-1:0] v;
      for (int i = 0; i < NCH; i++) v[i] = m_pend[i];
      return v;
   endfunction

   // Issue one command from a negedge, waiting (bounded) for cmd_ready
   task automatic send(input int op, input int ch, input int ld, input bit os, output int waited);
      cmd_valid = 1'b1; cmd_op = 2'(op); cmd_ch = CHW'(ch); cmd_load = 16'(ld); cmd_oneshot = os;
      waited = 0;
      while (cmd_ready !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 100) check("cmd_timeout", 32'(0), 32'(1));
      @(negedge clk);
      cmd_valid = 1'b0;
      m_cmd(op, ch, ld, os);
   endtask

   // Tick from IDLE (optionally with a same-edge START); checks each sweep slot
   task automatic tick(input bit with_cmd, input int ch, input int ld, input bit os);
      logic [NCH-1:0] old_v, new_v, exp_v;
      old_v = m_vec();
      tick_in = 1'b1;
      if (with_cmd) begin
         cmd_valid = 1'b1; cmd_op = 2'd1; cmd_ch = CHW'(ch); cmd_load = 16'(ld); cmd_oneshot = os;
      end
      @(negedge clk);
      tick_in = 1'b0;
      cmd_valid = 1'b0;
      if (with_cmd) m_cmd(1, ch, ld, os);
      m_tick();
      new_v = m_vec();
      for (int k = 0; k <= NCH; k++) begin
         for (int i = 0; i < NCH; i++) exp_v[i] = (k >= i + 1) ? new_v[i] : old_v[i];
         check("pend_slot", 32'(irq_pending), 32'(exp_v));
         check("irq", 32'(irq), 32'(|exp_v));
         check("busy", 32'(busy), 32'(k < NCH));
         check("cmd_ready", 32'(cmd_ready), 32'(k == NCH));
         if (k < NCH) @(negedge clk);
      end
`ifdef TIMER_SCHED_OVERRUN_EN
      check("overrun", 32'(overrun), 32'(m_ovr));
`endif
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   int w;

   initial begin
      rst_n = 1'b0; tick_in = 1'b0;
      cmd_valid = 1'b0; cmd_op = '0; cmd_ch = '0; cmd_load = '0; cmd_oneshot = 1'b0;
      cmd2_valid = 1'b0; cmd2_op = '0; cmd2_ch = '0; cmd2_load = '0; cmd2_oneshot = 1'b0;
      m_reset();
      wait_cycles(2);
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_ready", 32'(cmd_ready), 32'(1));
      check("rst_pend", 32'(irq_pending), 32'(0));
      check("rst_irq", 32'(irq), 32'(0));
`ifdef TIMER_SCHED_OVERRUN_EN
      check("rst_ovr", 32'(overrun), 32'(0));
`endif
      rst_n = 1'b1;
      wait_cycles(1);

      // Reset mid-sweep
      send(1, 0, 0, 0, w);
      send(1, 2, 1, 0, w);
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'(0));
      check("midrst_ready", 32'(cmd_ready), 32'(1));
      check("midrst_pend", 32'(irq_pending), 32'(0));
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int t = 0; t < 5; t++) begin
         tick(0, 0, 0, 0);
         check("postrst_quiet", 32'(irq_pending), 32'(0));
      end

      // One-shot ch1, load 3, ticks 8 cycles apart
      send(1, 1, 3, 1, w);
      for (int t = 1; t <= 6; t++) begin
         tick(0, 0, 0, 0);
         wait_cycles(3);
         if (t < 4) check("os_before", 32'(irq_pending[1]), 32'(0));
         if (t == 4) begin
            check("os_fire", 32'(irq_pending[1]), 32'(1));
            send(2, 1, 0, 0, w);
         end
         if (t > 4) check("os_no_refire", 32'(irq_pending[1]), 32'(0));
      end

      // Periodic ch0, load 2, then load 0
      send(1, 0, 2, 0, w);
      for (int t = 1; t <= 9; t++) begin
         tick(0, 0, 0, 0);
         check("per_pend", 32'(irq_pending[0]), 32'((t % 3) == 0));
         if (irq_pending[0]) send(2, 0, 0, 0, w);
      end
      send(1, 0, 0, 0, w);
      for (int t = 0; t < 3; t++) begin
         tick(0, 0, 0, 0);
         check("per0_pend", 32'(irq_pending[0]), 32'(1));
         send(2, 0, 0, 0, w);
      end
      send(0, 0, 0, 0, w);

      // Tick coincident with START ch2 load 0
      tick(1, 2, 0, 0);
      check("simul_pend", 32'(irq_pending[2]), 32'(1));
      // Command presented during a sweep waits for IDLE
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
      m_tick();
      check("sweep_ready", 32'(cmd_ready), 32'(0));
      send(2, 2, 0, 0, w);
      check("sweep_wait", 32'(w), 32'(NCH));
      check("sweep_clr", 32'(irq_pending[2]), 32'(0));
      send(0, 2, 0, 0, w);

      // Tick two cycles after the previous one is dropped
      send(1, 3, 1, 0, w);
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
      m_tick();
      @(negedge clk);
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
      m_ovr = 1;
      wait_cycles(3);
      check("drop_pend", 32'(irq_pending), 32'(m_vec()));
`ifdef TIMER_SCHED_OVERRUN_EN
      check("ovr_set", 32'(overrun), 32'(1));
`endif
      tick(0, 0, 0, 0);
      check("drop_next", 32'(irq_pending[3]), 32'(1));
      send(3, 0, 0, 0, w);
`ifdef TIMER_SCHED_OVERRUN_EN
      check("ovr_clr", 32'(overrun), 32'(0));
`endif
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
      m_tick();
      @(negedge clk);
      tick_in = 1'b1;
      cmd_valid = 1'b1; cmd_op = 2'd3; cmd_ch = '0; cmd_load = '0; cmd_oneshot = 1'b0;
      @(negedge clk);
      tick_in = 1'b0;
`ifdef TIMER_SCHED_OVERRUN_EN
      check("ovr_set_wins", 32'(overrun), 32'(1));
`endif
      send(3, 0, 0, 0, w);
`ifdef TIMER_SCHED_OVERRUN_EN
      check("ovr_clr2", 32'(overrun), 32'(0));
`endif
      send(0, 3, 0, 0, w);
      send(2, 3, 0, 0, w);

      // STOP mid-count freezes the channel
      send(1, 3, 4, 0, w);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      send(0, 3, 0, 0, w);
      for (int t = 0; t < 5; t++) begin
         tick(0, 0, 0, 0);
         check("stop_frozen", 32'(irq_pending[3]), 32'(0));
      end

      // cmd_ch == NCH on a 3-channel instance: accepted, no effect
      do_reset();
      cmd2_valid = 1'b1; cmd2_op = 2'd1; cmd2_ch = CHW'(NCH2); cmd2_load = '0; cmd2_oneshot = 1'b0;
      w = 0;
      while (cmd2_ready !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("inv_ready", 32'(cmd2_ready), 32'(1));
      @(negedge clk);
      cmd2_valid = 1'b0;
      for (int t = 0; t < 3; t++) begin
         tick(0, 0, 0, 0);
         check("inv_pend", 32'(irq2_pending), 32'(0));
         check("inv_irq", 32'(irq2), 32'(0));
      end

      // Randomized commands and ticks
      do_reset();
      for (int it = 0; it < 200; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            tick(0, 0, 0, 0);
         end else begin
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, NCH - 1)),
                 int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)), w);
            check("rnd_pend", 32'(irq_pending), 32'(m_vec()));
         end
         wait_cycles(int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
